// File: rtl/antares_muldiv_unit_if.sv
// ============================================================================
// Module   : antares_muldiv_unit_if
// Brief    : Request/response bundle between the EX stage and the mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface antares_muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  op_valid;
    logic [3:0]            op_code;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic                  div_by_zero;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output op_valid, op_code, op_a, op_b, flush,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b, flush,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/antares_muldiv_unit.sv
// ============================================================================
// Module   : antares_muldiv_unit
// Brief    : Iterative multiply/divide unit owning the HI/LO register pair.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module antares_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  wire logic              clk,
    input  wire logic              rst,
    antares_muldiv_unit_if.slave   bus
);

    localparam logic [3:0] c_op_mult  = 4'd1;
    localparam logic [3:0] c_op_multu = 4'd2;
    localparam logic [3:0] c_op_div   = 4'd3;
    localparam logic [3:0] c_op_divu  = 4'd4;
    localparam logic [3:0] c_op_madd  = 4'd5;
    localparam logic [3:0] c_op_maddu = 4'd6;
    localparam logic [3:0] c_op_msub  = 4'd7;
    localparam logic [3:0] c_op_msubu = 4'd8;
    localparam logic [3:0] c_op_mthi  = 4'd9;
    localparam logic [3:0] c_op_mtlo  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_WIDTH-1:0]      r_cnt;
    logic [3:0]                r_op;
    logic                      r_sign_q;
    logic                      r_sign_r;
    logic [DATA_WIDTH-1:0]     r_opnd;
    logic [2*DATA_WIDTH-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]     r_hi;
    logic [DATA_WIDTH-1:0]     r_lo;
    logic                      r_done;
    logic                      r_dbz;

    logic                      w_busy;
    logic                      w_accept;
    logic                      w_is_mul;
    logic                      w_is_div;
    logic                      w_is_signed;
    logic                      w_b_zero;
    logic                      w_last;
    logic                      w_dbz_now;
    logic                      w_fin_write;
    logic [DATA_WIDTH-1:0]     w_mag_a;
    logic [DATA_WIDTH-1:0]     w_mag_b;
    logic [DATA_WIDTH:0]       w_mul_sum;
    logic [2*DATA_WIDTH-1:0]   w_mul_nxt;
    logic [DATA_WIDTH:0]       w_div_shift;
    logic                      w_div_ok;
    logic [DATA_WIDTH-1:0]     w_div_rem;
    logic [2*DATA_WIDTH-1:0]   w_div_nxt;
    logic [2*DATA_WIDTH-1:0]   w_prod;
    logic [DATA_WIDTH-1:0]     w_quo;
    logic [DATA_WIDTH-1:0]     w_rem;
    logic [2*DATA_WIDTH-1:0]   w_result;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_accept    = bus.op_valid & ~w_busy & ~bus.flush;
    assign w_is_mul    = (bus.op_code == c_op_mult)  | (bus.op_code == c_op_multu) |
                         (bus.op_code == c_op_madd)  | (bus.op_code == c_op_maddu) |
                         (bus.op_code == c_op_msub)  | (bus.op_code == c_op_msubu);
    assign w_is_div    = (bus.op_code == c_op_div) | (bus.op_code == c_op_divu);
    assign w_is_signed = (bus.op_code == c_op_mult) | (bus.op_code == c_op_div) |
                         (bus.op_code == c_op_madd) | (bus.op_code == c_op_msub);
    assign w_b_zero    = (bus.op_b == '0);
    assign w_last      = (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));
    assign w_dbz_now   = w_accept & w_is_div & w_b_zero;
    assign w_fin_write = (r_state == ST_FIN) & ~bus.flush;

    // Two's-complement negation of MIN yields 2^(W-1), which is the correct unsigned magnitude
    assign w_mag_a = (w_is_signed & bus.op_a[DATA_WIDTH-1]) ? (~bus.op_a + 1'b1) : bus.op_a;
    assign w_mag_b = (w_is_signed & bus.op_b[DATA_WIDTH-1]) ? (~bus.op_b + 1'b1) : bus.op_b;

    // Multiply: accumulator upper half holds the partial sum, lower half the remaining multiplier bits
    assign w_mul_sum = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]} +
                       (r_acc[0] ? {1'b0, r_opnd} : {(DATA_WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_mul_sum, r_acc[DATA_WIDTH-1:1]};

    // Divide: accumulator upper half is the remainder, lower half shifts dividend out / quotient in
    assign w_div_shift = {r_acc[2*DATA_WIDTH-1:DATA_WIDTH], r_acc[DATA_WIDTH-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_rem   = w_div_ok ? DATA_WIDTH'(w_div_shift - {1'b0, r_opnd})
                                  : w_div_shift[DATA_WIDTH-1:0];
    assign w_div_nxt   = {w_div_rem, r_acc[DATA_WIDTH-2:0], w_div_ok};

    assign w_prod = r_sign_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_sign_q ? (~r_acc[DATA_WIDTH-1:0] + 1'b1) : r_acc[DATA_WIDTH-1:0];
    assign w_rem  = r_sign_r ? (~r_acc[2*DATA_WIDTH-1:DATA_WIDTH] + 1'b1)
                             : r_acc[2*DATA_WIDTH-1:DATA_WIDTH];

    always_comb begin
        w_result = w_prod;
        case (r_op)
            c_op_madd, c_op_maddu: w_result = {r_hi, r_lo} + w_prod;
            c_op_msub, c_op_msubu: w_result = {r_hi, r_lo} - w_prod;
            c_op_div,  c_op_divu:  w_result = {w_rem, w_quo};
            default:               w_result = w_prod;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept & w_is_mul)
                    w_state_nxt = ST_MUL;
                else if (w_accept & w_is_div & ~w_b_zero)
                    w_state_nxt = ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                if (bus.flush)
                    w_state_nxt = ST_IDLE;
                else if (w_last)
                    w_state_nxt = ST_FIN;
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= w_fin_write | w_dbz_now;
            r_dbz  <= w_dbz_now;
            if (w_accept) begin
                r_op     <= bus.op_code;
                r_cnt    <= '0;
                r_sign_q <= w_is_signed & (bus.op_a[DATA_WIDTH-1] ^ bus.op_b[DATA_WIDTH-1]);
                r_sign_r <= w_is_signed & bus.op_a[DATA_WIDTH-1];
                if (w_is_div) begin
                    r_opnd <= w_mag_b;
                    r_acc  <= {{DATA_WIDTH{1'b0}}, w_mag_a};
                end else begin
                    r_opnd <= w_mag_a;
                    r_acc  <= {{DATA_WIDTH{1'b0}}, w_mag_b};
                end
                if (bus.op_code == c_op_mthi)
                    r_hi <= bus.op_a;
                if (bus.op_code == c_op_mtlo)
                    r_lo <= bus.op_a;
            end
            if (r_state == ST_MUL) begin
                r_acc <= w_mul_nxt;
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
            if (r_state == ST_DIV) begin
                r_acc <= w_div_nxt;
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
            if (w_fin_write) begin
                r_hi <= w_result[2*DATA_WIDTH-1:DATA_WIDTH];
                r_lo <= w_result[DATA_WIDTH-1:0];
            end
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_antares_muldiv_unit.sv
// ============================================================================
// Module   : tb_antares_muldiv_unit
// Brief    : Randomized and directed checks of the mul/div unit against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_antares_muldiv_unit;

    logic clk = 1'b0;
    logic rst;
    logic rst16;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    antares_muldiv_unit_if #(.DATA_WIDTH(32)) bus32 ();
    antares_muldiv_unit_if #(.DATA_WIDTH(16)) bus16 ();

    antares_muldiv_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    antares_muldiv_unit #(.DATA_WIDTH(16), .CNT_WIDTH(5)) u_dut16 (
        .clk (clk),
        .rst (rst16),
        .bus (bus16.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural HI/LO pair
    task automatic model_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                            output bit iter, output bit dz);
        longint      sa, sb;
        logic [63:0] acc, p;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        acc  = {m_hi, m_lo};
        iter = 1'b0;
        dz   = 1'b0;
        case (code)
            4'd1, 4'd5, 4'd7: begin p = 64'(sa * sb); iter = 1'b1; end
            4'd2, 4'd6, 4'd8: begin p = {32'd0, a} * {32'd0, b}; iter = 1'b1; end
            default:          p = '0;
        endcase
        case (code)
            4'd1, 4'd2: {m_hi, m_lo} = p;
            4'd5, 4'd6: {m_hi, m_lo} = acc + p;
            4'd7, 4'd8: {m_hi, m_lo} = acc - p;
            4'd3: begin
                if (b == 0) dz = 1'b1;
                else begin
                    m_hi = 32'(sa % sb);
                    m_lo = 32'(sa / sb);
                    iter = 1'b1;
                end
            end
            4'd4: begin
                if (b == 0) dz = 1'b1;
                else begin
                    m_hi = a % b;
                    m_lo = a / b;
                    iter = 1'b1;
                end
            end
            4'd9:  m_hi = a;
            4'd10: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        bit          iter, dz, seen, stable;
        int          nbusy;
        logic [31:0] pre_hi, pre_lo;
        pre_hi = m_hi;
        pre_lo = m_lo;
        model_op(code, a, b, iter, dz);
        @(negedge clk);
        bus32.op_valid = 1'b1;
        bus32.op_code  = code;
        bus32.op_a     = a;
        bus32.op_b     = b;
        @(posedge clk);
        #1;
        bus32.op_valid = 1'b0;
        bus32.op_a     = $urandom;
        bus32.op_b     = $urandom;
        if (iter) begin
            nbusy  = 0;
            seen   = 1'b0;
            stable = 1'b1;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (bus32.busy) begin
                    nbusy++;
                    if (bus32.hi !== pre_hi || bus32.lo !== pre_lo || bus32.done) stable = 1'b0;
                end
                if (bus32.done) seen = 1'b1;
            end
            check("done_seen",   64'(seen), 64'd1);
            check("busy_cycles", 64'(nbusy), 64'd33);
            check("hilo_stable", 64'(stable), 64'd1);
            check("busy_at_done", 64'(bus32.busy), 64'd0);
            check("dbz_clear",   64'(bus32.div_by_zero), 64'd0);
            check("hi", 64'(bus32.hi), 64'(m_hi));
            check("lo", 64'(bus32.lo), 64'(m_lo));
            @(negedge clk);
            check("done_width", 64'(bus32.done), 64'd0);
        end else begin
            @(negedge clk);
            check("busy_idle", 64'(bus32.busy), 64'd0);
            check("done_imm",  64'(bus32.done), 64'(dz));
            check("dbz_imm",   64'(bus32.div_by_zero), 64'(dz));
            check("hi_imm",    64'(bus32.hi), 64'(m_hi));
            check("lo_imm",    64'(bus32.lo), 64'(m_lo));
            if (dz) begin
                @(negedge clk);
                check("dbz_width", 64'(bus32.div_by_zero), 64'd0);
            end
        end
    endtask

    // Flush a MULTU after `when` cycles of busy; HI/LO and done must be untouched
    task automatic flush_op(input int when);
        bit seen_done;
        @(negedge clk);
        bus32.op_valid = 1'b1;
        bus32.op_code  = 4'd2;
        bus32.op_a     = $urandom;
        bus32.op_b     = $urandom;
        @(posedge clk);
        #1;
        bus32.op_valid = 1'b0;
        repeat (when) @(negedge clk);
        check("busy_pre_flush", 64'(bus32.busy), 64'd1);
        bus32.flush = 1'b1;
        @(posedge clk);
        #1;
        bus32.flush = 1'b0;
        seen_done = 1'b0;
        @(negedge clk);
        check("busy_post_flush", 64'(bus32.busy), 64'd0);
        repeat (40) begin
            if (bus32.done) seen_done = 1'b1;
            @(negedge clk);
        end
        check("flush_no_done", 64'(seen_done), 64'd0);
        check("flush_hi", 64'(bus32.hi), 64'(m_hi));
        check("flush_lo", 64'(bus32.lo), 64'(m_lo));
    endtask

    initial begin
        logic [3:0]  code;
        logic [31:0] a, b;
        int          nbusy;
        bit          seen;

        rst = 1'b1;
        rst16 = 1'b1;
        bus32.op_valid = 1'b0; bus32.op_code = '0; bus32.op_a = '0; bus32.op_b = '0; bus32.flush = 1'b0;
        bus16.op_valid = 1'b0; bus16.op_code = '0; bus16.op_a = '0; bus16.op_b = '0; bus16.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rst16 = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(bus32.busy), 64'd0);
        check("rst_done", 64'(bus32.done), 64'd0);
        check("rst_dbz",  64'(bus32.div_by_zero), 64'd0);
        check("rst_hilo", {bus32.hi, bus32.lo}, 64'd0);

        run_op(4'd1, 32'hFFFFFFFD, 32'd7);
        check("tp_mult", {bus32.hi, bus32.lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_op(4'd3, 32'hFFFFFFF9, 32'd2);
        check("tp_div_neg", {bus32.hi, bus32.lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
        check("tp_div_min", {bus32.hi, bus32.lo}, 64'h00000000_80000000);
        run_op(4'd4, 32'd5, 32'd0);
        check("tp_divu_zero", {bus32.hi, bus32.lo}, 64'h00000000_80000000);
        run_op(4'd9, 32'h1, 32'h0);
        run_op(4'd10, 32'hFFFFFFFF, 32'h0);
        run_op(4'd6, 32'd1, 32'd1);
        check("tp_maddu", {bus32.hi, bus32.lo}, 64'h00000002_00000000);
        run_op(4'd7, 32'd1, 32'd1);
        check("tp_msub", {bus32.hi, bus32.lo}, 64'h00000001_FFFFFFFF);

        flush_op(10);
        run_op(4'd2, 32'h12345678, 32'h9ABCDEF0);
        flush_op(33);

        // Flush in the same cycle as a request wins, even for MTHI
        @(negedge clk);
        bus32.op_valid = 1'b1; bus32.op_code = 4'd9; bus32.op_a = ~m_hi; bus32.flush = 1'b1;
        @(posedge clk);
        #1;
        bus32.op_valid = 1'b0; bus32.flush = 1'b0;
        @(negedge clk);
        check("flush_blocks_mthi", 64'(bus32.hi), 64'(m_hi));

        for (int n = 0; n < 40; n++) begin
            code = 4'($urandom_range(1, 10));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 5));
                3: a = 32'h80000000;
                default: ;
            endcase
            run_op(code, a, b);
        end

        // 16-bit instance: latency scales with width, and reset aborts mid-divide
        @(negedge clk);
        bus16.op_valid = 1'b1; bus16.op_code = 4'd2; bus16.op_a = 16'hFFFF; bus16.op_b = 16'hFFFF;
        @(posedge clk);
        #1;
        bus16.op_valid = 1'b0;
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (bus16.busy) nbusy++;
            if (bus16.done) seen = 1'b1;
        end
        check("w16_done", 64'(seen), 64'd1);
        check("w16_busy_cycles", 64'(nbusy), 64'd17);
        check("w16_hilo", {32'd0, bus16.hi, bus16.lo}, 64'hFFFE0001);

        @(negedge clk);
        bus16.op_valid = 1'b1; bus16.op_code = 4'd3; bus16.op_a = 16'd100; bus16.op_b = 16'd7;
        @(posedge clk);
        #1;
        bus16.op_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("w16_busy_mid", 64'(bus16.busy), 64'd1);
        rst16 = 1'b1;
        @(posedge clk);
        #1;
        rst16 = 1'b0;
        @(negedge clk);
        check("w16_rst_busy", 64'(bus16.busy), 64'd0);
        check("w16_rst_flags", {62'd0, bus16.done, bus16.div_by_zero}, 64'd0);
        check("w16_rst_hilo", {32'd0, bus16.hi, bus16.lo}, 64'd0);
        repeat (20) @(negedge clk);
        check("w16_no_late_done", 64'(bus16.done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
